// File: rtl/game_link_pkg.sv
// game_link_pkg: types and helpers shared by the board-to-board link TX and RX.
package game_link_pkg;

  localparam int FRAME_DATA_BITS = 8;

  // Frame payload, bit 7 down to bit 0.
  typedef struct packed {
    logic       throw;
    logic       p2_ready;
    logic       p1_ready;
    logic [4:0] power;
  } link_payload_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } link_state_t;

  // Even parity bit: makes the total count of ones over data+parity even.
  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/game_link_rx.sv
// game_link_rx: synchronises the peer line, deserialises one frame at a time
// and reports, on the stop-sample cycle, whether the frame was good.
module game_link_rx
  import game_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 60
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       serial_rx,
  output logic                       frame_done,
  output logic                       frame_ok,
  output logic [FRAME_DATA_BITS-1:0] frame_data
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(FRAME_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_DATA_BITS - 1);

  logic                       sync1, sync2, sync_prev;
  link_state_t                state, state_nx;
  logic [CW-1:0]              cnt, cnt_nx;
  logic [IW-1:0]              idx, idx_nx;
  logic [FRAME_DATA_BITS-1:0] shift, shift_nx;
  logic                       parity, parity_nx;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= serial_rx;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  // RX FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shift  <= '0;
      parity <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      shift  <= shift_nx;
      parity <= parity_nx;
    end
  end

  // Next-state logic: start is confirmed mid-bit, every later bit sampled one bit period apart.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    idx_nx     = idx;
    shift_nx   = shift;
    parity_nx  = parity;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (sync_prev && !sync2) state_nx = START;
        else                     state_nx = IDLE;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          idx_nx = '0;
          // A line already back high at mid-start is a glitch, not a frame.
          if (sync2) state_nx = IDLE;
          else       state_nx = DATA;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          shift_nx = {sync2, shift[FRAME_DATA_BITS-1:1]};
          if (idx == IDX_LAST) begin
            state_nx = PARITY;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = DATA;
          end
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        if (cnt == BIT_LAST) begin
          cnt_nx    = '0;
          parity_nx = sync2;
          state_nx  = STOP;
        end else begin
          state_nx = PARITY;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx     = '0;
          frame_done = 1'b1;
          frame_ok   = sync2 && (even_parity(shift) == parity);
          state_nx   = IDLE;
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign frame_data = shift;

endmodule

// File: rtl/game_link.sv
// game_link: serial link between the two game boards. Sends the local
// ready/power/throw state as 11-bit frames and drives the peer-state outputs
// from frames received on serial_rx, with a link-alive timeout.
module game_link
  import game_link_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 60,
  parameter int REFRESH_CYCLES = 60_000,
  parameter int TIMEOUT_CYCLES = 240_000
) (
  input  logic       clk60MHz,
  input  logic       rst_n,
  input  logic       tx_player1_ready,
  input  logic       tx_player2_ready,
  input  logic [4:0] tx_power,
  input  logic       tx_throw_flag,
  output logic       serial_tx,
  input  logic       serial_rx,
  output logic       rx_player1_ready,
  output logic       rx_player2_ready,
  output logic [4:0] rx_power,
  output logic       rx_throw_flag,
  output logic       link_ok,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(FRAME_DATA_BITS);
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(FRAME_DATA_BITS - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_FULL = TW'(TIMEOUT_CYCLES);

  link_payload_t              cur_payload;
  logic [FRAME_DATA_BITS-1:0] tx_frame;   // payload being sent, and the last one sent
  logic                       throw_pending, trigger, snapshot, tx_line_nx;
  link_state_t                tx_state, tx_state_nx;
  logic [CW-1:0]              tx_cnt, tx_cnt_nx;
  logic [IW-1:0]              tx_idx, tx_idx_nx;
  logic [RW-1:0]              refresh_cnt;
  logic [TW-1:0]              tmo_cnt;
  logic                       rx_done, rx_ok;
  logic [FRAME_DATA_BITS-1:0] rx_data;

  assign cur_payload = {throw_pending | tx_throw_flag, tx_player2_ready, tx_player1_ready, tx_power};

  // Only the level fields count as "changed"; a throw always triggers on its own,
  // so a sent throw does not force an extra frame once it clears.
  assign trigger = ({cur_payload.p2_ready, cur_payload.p1_ready, cur_payload.power} != tx_frame[6:0])
                   || cur_payload.throw || (refresh_cnt == REFRESH_LAST);

  // TX next-state and next line level; the line is registered so it leaves IDLE one cycle after the trigger.
  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + 1'b1;
    tx_idx_nx   = tx_idx;
    tx_line_nx  = 1'b1;
    snapshot    = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_nx = '0;
        if (trigger) begin
          snapshot    = 1'b1;
          tx_state_nx = START;
          tx_line_nx  = 1'b0;
        end else begin
          tx_state_nx = IDLE;
        end
      end
      START: begin
        tx_line_nx = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_idx_nx   = '0;
          tx_state_nx = DATA;
          tx_line_nx  = tx_frame[0];
        end else begin
          tx_state_nx = START;
        end
      end
      DATA: begin
        tx_line_nx = tx_frame[tx_idx];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx = '0;
          if (tx_idx == IDX_LAST) begin
            tx_state_nx = PARITY;
            tx_line_nx  = even_parity(tx_frame);
          end else begin
            tx_idx_nx   = tx_idx + 1'b1;
            tx_state_nx = DATA;
            tx_line_nx  = tx_frame[tx_idx + 1'b1];
          end
        end else begin
          tx_state_nx = DATA;
        end
      end
      PARITY: begin
        tx_line_nx = even_parity(tx_frame);
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = STOP;
          tx_line_nx  = 1'b1;
        end else begin
          tx_state_nx = PARITY;
        end
      end
      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_state_nx = IDLE;
        end else begin
          tx_state_nx = STOP;
        end
      end
      default: begin
        tx_cnt_nx   = '0;
        tx_state_nx = IDLE;
      end
    endcase
  end

  // TX registers: FSM, line, payload snapshot, held throw and refresh counter.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      tx_state      <= IDLE;
      tx_cnt        <= '0;
      tx_idx        <= '0;
      serial_tx     <= 1'b1;
      tx_frame      <= '0;
      throw_pending <= 1'b0;
      refresh_cnt   <= '0;
    end else begin
      tx_state  <= tx_state_nx;
      tx_cnt    <= tx_cnt_nx;
      tx_idx    <= tx_idx_nx;
      serial_tx <= tx_line_nx;
      if (snapshot) tx_frame <= cur_payload;
      // A pulse consumed by this snapshot is already in the frame, so it is not held.
      throw_pending <= (throw_pending | tx_throw_flag) & ~snapshot;
      if (snapshot)                         refresh_cnt <= '0;
      else if (refresh_cnt != REFRESH_LAST) refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  game_link_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk60MHz),
    .rst_n     (rst_n),
    .serial_rx (serial_rx),
    .frame_done(rx_done),
    .frame_ok  (rx_ok),
    .frame_data(rx_data)
  );

  // Peer-state outputs, error pulse and link-alive timeout.
  always_ff @(posedge clk60MHz or negedge rst_n) begin
    if (!rst_n) begin
      rx_player1_ready <= 1'b0;
      rx_player2_ready <= 1'b0;
      rx_power         <= 5'd0;
      rx_throw_flag    <= 1'b0;
      link_ok          <= 1'b0;
      frame_err        <= 1'b0;
      tmo_cnt          <= '0;
    end else if (rx_done && rx_ok) begin
      rx_power         <= rx_data[4:0];
      rx_player1_ready <= rx_data[5];
      rx_player2_ready <= rx_data[6];
      rx_throw_flag    <= rx_data[7];
      link_ok          <= 1'b1;
      frame_err        <= 1'b0;
      tmo_cnt          <= '0;
    end else begin
      rx_throw_flag <= 1'b0;
      frame_err     <= rx_done;
      // Silence: drop the link and the peer ready levels, keep the last power.
      if (tmo_cnt >= TIMEOUT_LAST) begin
        tmo_cnt          <= TIMEOUT_FULL;
        link_ok          <= 1'b0;
        rx_player1_ready <= 1'b0;
        rx_player2_ready <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_game_link.sv
// tb_game_link: randomized self-checking bench for game_link with shortened timing.
module tb_game_link;

  localparam int CPB     = 24;
  localparam int REFRESH = 1000;
  localparam int TIMEOUT = 3000;

  logic       clk60MHz = 1'b0;
  logic       rst_n;
  logic       tx_player1_ready, tx_player2_ready, tx_throw_flag;
  logic [4:0] tx_power;
  logic       serial_tx, serial_rx;
  logic       rx_player1_ready, rx_player2_ready, rx_throw_flag;
  logic [4:0] rx_power;
  logic       link_ok, frame_err;
  logic       loop, drv_rx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, throw_cnt = 0, err_cnt = 0, rise_cyc = 0, fall_cyc = 0;
  logic lk_prev = 1'b0;
  int base, base_err, w;
  logic [10:0] bits;
  logic [6:0]  exp_fields;
  logic [4:0]  pw;
  logic        a, b, t;
  logic [7:0]  pl;

  always #5 clk60MHz = ~clk60MHz;

  assign serial_rx = loop ? serial_tx : drv_rx;

  game_link #(
    .CLKS_PER_BIT  (CPB),
    .REFRESH_CYCLES(REFRESH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk60MHz        (clk60MHz),
    .rst_n           (rst_n),
    .tx_player1_ready(tx_player1_ready),
    .tx_player2_ready(tx_player2_ready),
    .tx_power        (tx_power),
    .tx_throw_flag   (tx_throw_flag),
    .serial_tx       (serial_tx),
    .serial_rx       (serial_rx),
    .rx_player1_ready(rx_player1_ready),
    .rx_player2_ready(rx_player2_ready),
    .rx_power        (rx_power),
    .rx_throw_flag   (rx_throw_flag),
    .link_ok         (link_ok),
    .frame_err       (frame_err)
  );

  // Cycle counter
  always @(posedge clk60MHz) cyc <= cyc + 1;

  // Pulse counters and link_ok edge timestamps, sampled away from the active edge
  always @(negedge clk60MHz) begin
    if (rx_throw_flag) throw_cnt <= throw_cnt + 1;
    if (frame_err)     err_cnt   <= err_cnt + 1;
    lk_prev <= link_ok;
    if (link_ok && !lk_prev) rise_cyc <= cyc;
    if (!link_ok && lk_prev) fall_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk60MHz);
    #1;
  endtask

  // Expected line bits, index 0 first on the wire: start, payload LSB first, even parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] p);
    logic par;
    par = ($countones(p) % 2) == 1;
    return {1'b1, par, p, 1'b0};
  endfunction

  // Waits for a start bit on serial_tx, returns high samples seen first and the 11 mid-bit samples.
  task automatic capture_tx(input int budget, output int wait_cyc, output logic [10:0] fr);
    int n;
    n  = 0;
    fr = '1;
    tick(1);
    while (serial_tx !== 1'b0 && n < budget) begin
      n++;
      tick(1);
    end
    wait_cyc = n;
    check("tx_frame_seen", {31'd0, serial_tx}, 32'd0);
    if (serial_tx === 1'b0) begin
      tick(CPB / 2);
      fr[0] = serial_tx;
      for (int i = 1; i < 11; i++) begin
        tick(CPB);
        fr[i] = serial_tx;
      end
    end
  endtask

  // Drives one frame on the bench side of serial_rx, optionally corrupted.
  task automatic send_frame(input logic [7:0] p, input logic flip_par, input logic stop_bit);
    logic [10:0] f;
    f     = exp_frame(p);
    f[9]  = f[9] ^ flip_par;
    f[10] = stop_bit;
    for (int i = 0; i < 11; i++) begin
      drv_rx = f[i];
      tick(CPB);
    end
    drv_rx = 1'b1;
    tick(CPB);
  endtask

  // Hard stop if anything unexpectedly stalls
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; loop = 1'b0; drv_rx = 1'b1;
    tx_player1_ready = 1'b0; tx_player2_ready = 1'b0; tx_power = 5'd0; tx_throw_flag = 1'b0;
    tick(3);
    check("reset_serial_tx", {31'd0, serial_tx}, 32'd1);
    check("reset_rx_fields", {rx_throw_flag, rx_player2_ready, rx_player1_ready, rx_power}, 32'd0);
    check("reset_link_ok", {31'd0, link_ok}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;

    // Idle with all-zero inputs: only the refresh frame appears.
    capture_tx(REFRESH + 50, w, bits);
    check("idle_refresh_time", w, REFRESH - 1);
    check("idle_frame", bits, exp_frame(8'h00));

    // Level change sends promptly.
    tick(20);
    tx_power = 5'd17; tx_player1_ready = 1'b1;
    capture_tx(50, w, bits);
    check("tx_start_latency", {31'd0, w <= 1}, 32'd1);
    check("tx_frame_0x31", bits, exp_frame(8'h31));
    check("tx_parity_0x31", {31'd0, bits[9]}, 32'd1);

    // Loopback with random levels; last iteration is power 9 with a throw.
    tick(20);
    loop = 1'b1;
    for (int it = 0; it < 6; it++) begin
      pw = 5'($urandom_range(0, 31));
      a  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      t  = 1'($urandom_range(0, 1));
      if (it == 5) begin
        pw = 5'd9;
        t  = 1'b1;
      end
      if ({b, a, pw} == {tx_player2_ready, tx_player1_ready, tx_power}) a = ~a;
      base = throw_cnt;
      tx_power = pw; tx_player1_ready = a; tx_player2_ready = b; tx_throw_flag = t;
      tick(1);
      tx_throw_flag = 1'b0;
      tick(600);
      check("lb_fields", {rx_player2_ready, rx_player1_ready, rx_power}, {b, a, pw});
      check("lb_link_ok", {31'd0, link_ok}, 32'd1);
      check("lb_throw_pulses", throw_cnt - base, {31'd0, t});
    end
    capture_tx(REFRESH + 300, w, bits);
    check("refresh_throw_clear", bits, exp_frame({1'b0, b, a, 5'd9}));
    tick(CPB);
    check("refresh_no_extra_throw", throw_cnt - base, 32'd1);
    tick(20);
    loop = 1'b0;
    tick(50);

    // Peer frames driven by the bench.
    for (int it = 0; it < 4; it++) begin
      pl   = 8'($urandom_range(0, 255));
      base = throw_cnt;
      send_frame(pl, 1'b0, 1'b1);
      check("rx_fields", {rx_player2_ready, rx_player1_ready, rx_power}, {25'd0, pl[6:0]});
      check("rx_throw_pulses", throw_cnt - base, {31'd0, pl[7]});
      check("rx_link_ok", {31'd0, link_ok}, 32'd1);
      exp_fields = pl[6:0];
    end

    // Flipped parity, carrying a throw that must not be delivered.
    base_err = err_cnt; base = throw_cnt;
    pl = 8'($urandom_range(0, 255)) | 8'h80;
    send_frame(pl, 1'b1, 1'b1);
    check("par_err_pulse", err_cnt - base_err, 32'd1);
    check("par_err_hold", {rx_player2_ready, rx_player1_ready, rx_power}, {25'd0, exp_fields});
    check("par_err_link", {31'd0, link_ok}, 32'd1);
    check("par_err_no_throw", throw_cnt - base, 32'd0);

    // Bad stop bit.
    base_err = err_cnt;
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    tick(CPB);
    check("stop_err_pulse", err_cnt - base_err, 32'd1);
    check("stop_err_hold", {rx_player2_ready, rx_player1_ready, rx_power}, {25'd0, exp_fields});

    // Short low glitch.
    base_err = err_cnt; base = throw_cnt;
    drv_rx = 1'b0;
    tick(10);
    drv_rx = 1'b1;
    tick(300);
    check("glitch_no_err", err_cnt - base_err, 32'd0);
    check("glitch_hold", {rx_player2_ready, rx_player1_ready, rx_power}, {25'd0, exp_fields});
    check("glitch_no_throw", throw_cnt - base, 32'd0);

    // Reset while the TX line is low.
    tx_power = tx_power + 5'd1;
    w = 0;
    tick(1);
    while (serial_tx !== 1'b0 && w < 600) begin
      w++;
      tick(1);
    end
    check("tx_busy_seen", {31'd0, serial_tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_tx_line", {31'd0, serial_tx}, 32'd1);
    check("reset_mid_tx_link", {31'd0, link_ok}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // One valid frame, then silence until the link times out.
    pw = 5'($urandom_range(0, 31));
    send_frame({1'b0, 1'b1, 1'b1, pw}, 1'b0, 1'b1);
    check("tmo_pre_fields", {rx_player2_ready, rx_player1_ready, rx_power}, {25'd0, 2'b11, pw});
    check("tmo_pre_link", {31'd0, link_ok}, 32'd1);
    for (int i = 0; i < TIMEOUT + 200 && link_ok === 1'b1; i++) tick(1);
    check("tmo_link_dropped", {31'd0, link_ok}, 32'd0);
    tick(2);
    check("tmo_exact_cycles", fall_cyc - rise_cyc, TIMEOUT);
    check("tmo_ready_cleared", {30'd0, rx_player2_ready, rx_player1_ready}, 32'd0);
    check("tmo_power_held", {27'd0, rx_power}, {27'd0, pw});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
